// File: rtl/base_aframe.sv
// base_aframe -- multi-channel frame tracker for interleaved valid/ready/end
// streams. It observes the stream passively and never drives the ready signal.
// For every beat it flags whether the beat is the first or the last of a frame,
// and it gives the beat's index within that frame. One cycle after a frame
// completes, it reports the frame's length and channel.
//
// Optional feature (compile-time macro BASE_AFRAME_LENCHK_EN):
//   When defined, a frame that reaches maxbeats beats without an end marker is
//   force-terminated. The module then reports o_len = maxbeats together with a
//   one-cycle o_err pulse. When undefined, o_err is tied to 0 and the beat
//   counts simply saturate.
//
// Parameters:
//   cw       channel-id width (channel count = 2**cw)
//   bw       beat-counter width (counts saturate at 2**bw-1)
//   maxbeats maximum legal frame length (used only by the optional feature)
//
// Ports:
//   clk      clock
//   reset    asynchronous active-low reset
//   i_v      beat valid
//   i_r      beat ready (a beat is accepted when i_v & i_r)
//   i_e      end-of-frame marker on the current beat
//   i_c      channel id of the current beat
//   o_first  current beat opens a frame on channel i_c (combinational)
//   o_last   current beat ends the frame (combinational)
//   o_beat   index of the current beat within its frame (combinational)
//   o_busy   per-channel frame-in-progress vector (registered)
//   o_len_v  one-cycle pulse: a frame completed
//   o_len_c  channel of the completed frame (held between pulses)
//   o_len    length in beats of the completed frame (held between pulses)
//   o_err    one-cycle pulse: a frame overran maxbeats
module base_aframe #(
  parameter int cw       = 2,
  parameter int bw       = 8,
  parameter int maxbeats = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_v,
  input  logic              i_r,
  input  logic              i_e,
  input  logic [cw-1:0]     i_c,
  output logic              o_first,
  output logic              o_last,
  output logic [bw-1:0]     o_beat,
  output logic [2**cw-1:0]  o_busy,
  output logic              o_len_v,
  output logic [cw-1:0]     o_len_c,
  output logic [bw-1:0]     o_len,
  output logic              o_err
);

  localparam int            NCH     = 2**cw;
  localparam logic [bw-1:0] CNT_MAX = '1;

  if (cw < 1 || maxbeats < 2 || maxbeats > 2**bw-1) begin : g_param_check
    $error("base_aframe: illegal parameter combination");
  end

  // Per-channel state is gathered into these views for the shared datapath.
  logic [NCH-1:0] act_vec;
  logic [bw-1:0]  cnt_arr [NCH];

  logic          cur_act;
  logic [bw-1:0] cur_cnt;
  logic [bw-1:0] beat_inc;
  logic          accept;
  logic          force_term;
  logic          close;

  assign cur_act = act_vec[i_c];
  assign cur_cnt = cnt_arr[i_c];

  // These outputs depend only on the stored state of the addressed channel,
  // so they stay stable for as long as a stalled beat is held.
  assign o_first = i_v & ~cur_act;
  assign o_last  = i_v & i_e;
  assign o_beat  = (i_v & cur_act) ? cur_cnt : '0;

  // Next index, saturating. This value is also the length of the frame when
  // the current beat closes it. On a forced close, o_beat is maxbeats-1, and
  // maxbeats lies within the counter range, so this value then equals maxbeats.
  assign beat_inc = (o_beat == CNT_MAX) ? CNT_MAX : o_beat + bw'(1);
  assign accept   = i_v & i_r;

`ifdef BASE_AFRAME_LENCHK_EN
  localparam logic [bw-1:0] LAST_IDX = bw'(maxbeats - 1);
  assign force_term = accept & ~i_e & (o_beat == LAST_IDX);
`else
  assign force_term = 1'b0;
`endif

  assign close = accept & (i_e | force_term);

  // One independent state slice per channel. Only the slice addressed by i_c
  // reacts to an accepted beat.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic          act_q;
    logic [bw-1:0] cnt_q;
    logic          hit;

    assign hit = accept & (i_c == cw'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        act_q <= 1'b0;
        cnt_q <= '0;
      end else if (hit) begin
        if (close) begin
          act_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          act_q <= 1'b1;
          cnt_q <= beat_inc;
        end
      end
    end

    assign act_vec[gi] = act_q;
    assign cnt_arr[gi] = cnt_q;
  end

  assign o_busy = act_vec;

  // Completion report, one cycle after the closing beat.
  logic          len_v_q, len_v_d;
  logic [cw-1:0] len_c_q, len_c_d;
  logic [bw-1:0] len_q,   len_d;
  logic          err_q,   err_d;

  always_comb begin
    len_v_d = close;
    err_d   = force_term;
    len_c_d = len_c_q;
    len_d   = len_q;
    if (close) begin
      len_c_d = i_c;
      len_d   = beat_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_v_q <= 1'b0;
      len_c_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      len_v_q <= len_v_d;
      len_c_q <= len_c_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign o_len_v = len_v_q;
  assign o_len_c = len_c_q;
  assign o_len   = len_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_base_aframe.sv
module tb_base_aframe;
  localparam int CW   = 2;
  localparam int BW   = 4;
  localparam int MAXB = 4;
  localparam int NCH  = 4;
  localparam int MAXC = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_v = 1'b0, i_r = 1'b0, i_e = 1'b0;
  logic [CW-1:0] i_c = '0;
  logic          o_first, o_last, o_len_v, o_err;
  logic [BW-1:0] o_beat, o_len;
  logic [NCH-1:0] o_busy;
  logic [CW-1:0] o_len_c;

  always #5 clk = ~clk;

  base_aframe #(.cw(CW), .bw(BW), .maxbeats(MAXB)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_e(i_e), .i_c(i_c),
    .o_first(o_first), .o_last(o_last), .o_beat(o_beat), .o_busy(o_busy),
    .o_len_v(o_len_v), .o_len_c(o_len_c), .o_len(o_len), .o_err(o_err)
  );

  typedef struct {
    logic           first;
    logic           last;
    logic [BW-1:0]  beat;
    logic [NCH-1:0] busy;
  } beat_exp_t;

  typedef struct {
    logic [CW-1:0] c;
    logic [BW-1:0] len;
    logic          err;
  } len_exp_t;

  beat_exp_t beat_q[$];
  len_exp_t  len_q[$];
  int        mlen [NCH];   // beats accepted so far in each channel's open frame
  bit        mon_en = 1'b0;
  int        checks = 0;
  int        passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int sat(input int n);
    return (n > MAXC) ? MAXC : n;
  endfunction

  // Reference model: a frame is just a running beat count per channel.
  task automatic drive(input bit v, input bit r, input bit e, input int c);
    beat_exp_t x;
    len_exp_t  l;
    @(posedge clk);
    #1;
    i_v = v; i_r = r; i_e = e; i_c = CW'(c);
    x.first = v && (mlen[c] == 0);
    x.last  = v && e;
    x.beat  = v ? BW'(sat(mlen[c])) : '0;
    for (int k = 0; k < NCH; k++) x.busy[k] = (mlen[k] != 0);
    beat_q.push_back(x);
    if (v && r) begin
      mlen[c]++;
      if (e) begin
        l.c = CW'(c); l.len = BW'(sat(mlen[c])); l.err = 1'b0;
        len_q.push_back(l);
        mlen[c] = 0;
      end
`ifdef BASE_AFRAME_LENCHK_EN
      else if (mlen[c] == MAXB) begin
        l.c = CW'(c); l.len = BW'(MAXB); l.err = 1'b1;
        len_q.push_back(l);
        mlen[c] = 0;
      end
`endif
    end
    mon_en = 1'b1;
  endtask

  task automatic stop_mon();
    @(posedge clk);
    #1;
    i_v = 1'b0; i_r = 1'b0; i_e = 1'b0;
    mon_en = 1'b0;
  endtask

  // Monitor: compares the DUT against the scoreboard queues, sampling at the
  // falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      beat_exp_t b;
      len_exp_t  l;
      if (beat_q.size() == 0) begin
        check("beat_q_empty", 32'd1, 32'd0);
      end else begin
        b = beat_q.pop_front();
        check("o_first", o_first, b.first);
        check("o_last",  o_last,  b.last);
        check("o_beat",  o_beat,  b.beat);
        check("o_busy",  o_busy,  b.busy);
      end
      if (o_len_v === 1'b1) begin
        if (len_q.size() == 0) begin
          check("unexpected_len_v", 32'd1, 32'd0);
        end else begin
          l = len_q.pop_front();
          check("o_len_c", o_len_c, l.c);
          check("o_len",   o_len,   l.len);
          check("o_err",   o_err,   l.err);
          $display("frame ch %0d len %0d err %0d", o_len_c, o_len, o_err);
        end
      end else begin
        check("o_err_idle", o_err, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NCH; k++) mlen[k] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  o_busy,  0);
    check("rst_len_v", o_len_v, 0);
    check("rst_len_c", o_len_c, 0);
    check("rst_len",   o_len,   0);
    check("rst_err",   o_err,   0);
    reset = 1'b1;

    // 4-beat frame on ch1
    for (int i = 0; i < 4; i++) drive(1, 1, i == 3, 1);
    drive(0, 0, 0, 0);
    // single-beat frame on ch0
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    // interleaved ch2/ch3
    drive(1, 1, 0, 2); drive(1, 1, 0, 3); drive(1, 1, 1, 2);
    drive(1, 1, 0, 3); drive(1, 1, 1, 3);
    drive(0, 0, 0, 0);
    // stalled first beat on ch0, then accepted, then closed
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    // 6-beat ch0 frame (forced close with the length check enabled)
    for (int i = 0; i < 6; i++) drive(1, 1, i == 5, 0);
    // long ch3 frame to reach counter saturation
    for (int i = 0; i < 20; i++) drive(1, 1, i == 19, 3);
    // back-to-back end beats on different channels
    drive(1, 1, 1, 1); drive(1, 1, 1, 2);
    drive(0, 0, 0, 0);

    // randomized interleaved traffic
    for (int i = 0; i < 600; i++)
      drive(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
            int'($urandom_range(NCH - 1, 0)));
    // close every open frame, then let the last report drain
    for (int k = 0; k < NCH; k++) if (mlen[k] != 0) drive(1, 1, 1, k);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    // reset asserted mid-frame on ch1 after beat 2
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 1);
    stop_mon();
    reset = 1'b0;
    #1;
    check("midrst_busy",  o_busy,  0);
    check("midrst_len_v", o_len_v, 0);
    check("midrst_len",   o_len,   0);
    check("midrst_len_c", o_len_c, 0);
    for (int k = 0; k < NCH; k++) mlen[k] = 0;
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    stop_mon();

    check("len_q_drained", len_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
